// File: rtl/lipsi_core_param.sv
// Lipsi multicycle accumulator core. It fetches 8-bit instructions from an external ROM
// and keeps an accumulator, a carry flag and a small internal register memory.
module lipsi_core_param #(
    parameter int DATA_W   = 8,
    parameter int IMEM_AW  = 8,
    parameter int DMEM_AW  = 4,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [7:0]         imem_rdata,
    output logic [DATA_W-1:0]  A,
    output logic               carry,
    output logic               halted
);

    localparam int MEM_DEPTH = 1 << DMEM_AW;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_OPERAND = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [IMEM_AW-1:0]  pc_r, pc_s, pc_inc_s;
    logic [DATA_W-1:0]   a_r, a_s;
    logic                c_r, c_s;
    logic                halted_r, halted_s;
    logic                is_branch_r, is_branch_s;
    logic [2:0]          sel_r, sel_s;
    logic                take_s;
    logic                mem_we_s;
    logic [DMEM_AW-1:0]  mem_wa_s;
    logic [DATA_W-1:0]   mem_r [MEM_DEPTH];

    // Returns {carry, result}; borrow falls out of the extra top bit of the widened subtraction.
    function automatic logic [DATA_W:0] alu_f(input logic [2:0] fff, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b, input logic c);
        logic [DATA_W:0] r;
        case (fff)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, c};
            3'd3:    r = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, c};
            3'd4:    r = {c, a & b};
            3'd5:    r = {c, a | b};
            3'd6:    r = {c, a ^ b};
            3'd7:    r = {c, b};
            default: r = {c, a};
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W:0] shift_f(input logic [1:0] ss, input logic [DATA_W-1:0] a,
                                                input logic c);
        logic [DATA_W:0] r;
        case (ss)
            2'd0:    r = {a[DATA_W-1], a[DATA_W-2:0], 1'b0};
            2'd1:    r = {a[0], 1'b0, a[DATA_W-1:1]};
            2'd2:    r = {a[DATA_W-1], a[DATA_W-2:0], c};
            2'd3:    r = {a[0], c, a[DATA_W-1:1]};
            default: r = {c, a};
        endcase
        return r;
    endfunction

    // Branch condition is evaluated on the A/C values present in the OPERAND cycle.
    always_comb begin
        case (sel_r[1:0])
            2'd0:    take_s = 1'b1;
            2'd1:    take_s = (a_r == {DATA_W{1'b0}});
            2'd2:    take_s = (a_r != {DATA_W{1'b0}});
            2'd3:    take_s = c_r;
            default: take_s = 1'b0;
        endcase
    end

    // Next-state, decode and datapath update.
    always_comb begin
        state_s     = state_r;
        pc_inc_s    = pc_r + IMEM_AW'(1);
        pc_s        = pc_r;
        a_s         = a_r;
        c_s         = c_r;
        halted_s    = halted_r;
        is_branch_s = is_branch_r;
        sel_s       = sel_r;
        mem_we_s    = 1'b0;
        mem_wa_s    = imem_rdata[DMEM_AW-1:0];
        case (state_r)
            ST_FETCH: begin
                if (imem_rdata[7] == 1'b0) begin
                    {c_s, a_s} = alu_f(imem_rdata[6:4], a_r, mem_r[imem_rdata[DMEM_AW-1:0]], c_r);
                    pc_s       = pc_inc_s;
                end else if (imem_rdata[7:4] == 4'h8) begin
                    mem_we_s = 1'b1;
                    pc_s     = pc_inc_s;
                end else if (imem_rdata[7:3] == 5'b11000) begin
                    sel_s       = imem_rdata[2:0];
                    is_branch_s = 1'b0;
                    pc_s        = pc_inc_s;
                    state_s     = ST_OPERAND;
                end else if (imem_rdata[7:2] == 6'b110100) begin
                    sel_s       = {1'b0, imem_rdata[1:0]};
                    is_branch_s = 1'b1;
                    pc_s        = pc_inc_s;
                    state_s     = ST_OPERAND;
                end else if (imem_rdata[7:2] == 6'b111000) begin
                    {c_s, a_s} = shift_f(imem_rdata[1:0], a_r, c_r);
                    pc_s       = pc_inc_s;
                end else if (imem_rdata == 8'hFF) begin
                    halted_s = 1'b1;
                    state_s  = ST_HALT;
                end else begin
                    pc_s = pc_inc_s;
                end
            end
            ST_OPERAND: begin
                state_s = ST_FETCH;
                if (is_branch_r) begin
                    if (take_s) begin
                        pc_s = imem_rdata[IMEM_AW-1:0];
                    end else begin
                        pc_s = pc_inc_s;
                    end
                end else begin
                    {c_s, a_s} = alu_f(sel_r, a_r, DATA_W'(imem_rdata), c_r);
                    pc_s       = pc_inc_s;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // State, accumulator and register memory; en=0 freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_FETCH;
            pc_r        <= IMEM_AW'(RESET_PC);
            a_r         <= {DATA_W{1'b0}};
            c_r         <= 1'b0;
            halted_r    <= 1'b0;
            is_branch_r <= 1'b0;
            sel_r       <= 3'd0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (en) begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            a_r         <= a_s;
            c_r         <= c_s;
            halted_r    <= halted_s;
            is_branch_r <= is_branch_s;
            sel_r       <= sel_s;
            if (mem_we_s) begin
                mem_r[mem_wa_s] <= a_r;
            end
        end
    end

    assign imem_addr = pc_r;
    assign A         = a_r;
    assign carry     = c_r;
    assign halted    = halted_r;

endmodule
